// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS   = 4;
    localparam int KP_COLS   = 4;
    localparam int KP_CODE_W = 4;
    localparam int KP_KEYS   = KP_ROWS * KP_COLS;

    localparam logic [KP_ROWS-1:0] KP_ROW_RST = 4'b1110;

    function automatic logic [KP_CODE_W-1:0] kp_lowest(
        input logic [KP_KEYS-1:0] v
    );
        kp_lowest = '0;
        for (int i = KP_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                kp_lowest = KP_CODE_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level stability filter: the key matrix only follows the raw
// frame after DEBOUNCE_SCANS consecutive identical frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_i,
    input  logic [KP_KEYS-1:0] raw_i,
    output logic [KP_KEYS-1:0] keys_o,
    output logic [KP_KEYS-1:0] press_o,
    output logic [KP_KEYS-1:0] release_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [KP_KEYS-1:0] prev_q, prev_d;
    logic [KP_KEYS-1:0] keys_q, keys_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        prev_d    = prev_q;
        keys_d    = keys_q;
        cnt_d     = cnt_q;
        press_o   = '0;
        release_o = '0;
        if (frame_i) begin
            prev_d = raw_i;
            if (raw_i != prev_q) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_d == CNT_MAX && raw_i != keys_q) begin
                keys_d    = raw_i;
                press_o   = raw_i & ~keys_q;
                release_o = keys_q & ~raw_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            keys_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            keys_q <= keys_d;
            cnt_q  <= cnt_d;
        end
    end

    assign keys_o = keys_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with per-frame debounce and key events.
// Define KEYPAD_RELEASE_EN to add the key_release pulse output.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [KP_ROWS-1:0]   row,
    input  logic [KP_COLS-1:0]   col,
    output logic [KP_KEYS-1:0]   keys,
    output logic                 key_valid,
    output logic [KP_CODE_W-1:0] key_code
`ifdef KEYPAD_RELEASE_EN
    ,
    output logic                 key_release
`endif
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [KP_COLS-1:0]   col_s1_q, col_s2_q;
    logic [DW-1:0]        div_q, div_d;
    logic [1:0]           ridx_q, ridx_d;
    logic [KP_ROWS-1:0]   row_q, row_d;
    logic [KP_KEYS-1:0]   raw_q, raw_d;
    logic                 frame_q, frame_d;
    logic                 valid_q, valid_d;
    logic [KP_CODE_W-1:0] code_q, code_d;
    logic                 rel_q, rel_d;
    logic                 div_last;

    logic [KP_KEYS-1:0]   press_vec;
    logic [KP_KEYS-1:0]   rel_vec;

    assign div_last = (div_q == DIV_LAST);

    // Columns are sampled only at the end of each row period, long
    // after the strobe switch has settled through the synchronizer.
    always_comb begin
        div_d   = div_last ? '0 : div_q + DW'(1);
        ridx_d  = div_last ? ridx_q + 2'd1 : ridx_q;
        row_d   = div_last ? {row_q[KP_ROWS-2:0], row_q[KP_ROWS-1]} : row_q;
        raw_d   = raw_q;
        frame_d = div_last && (ridx_q == 2'd3);
        if (div_last) begin
            raw_d[{ridx_q, 2'b00} +: KP_COLS] = ~col_s2_q;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .frame_i  (frame_q),
        .raw_i    (raw_q),
        .keys_o   (keys),
        .press_o  (press_vec),
        .release_o(rel_vec)
    );

    always_comb begin
        valid_d = |press_vec;
        code_d  = code_q;
        rel_d   = 1'b0;
        if (|press_vec) begin
            code_d = kp_lowest(press_vec);
        end
`ifdef KEYPAD_RELEASE_EN
        rel_d = |rel_vec;
        if (!(|press_vec) && (|rel_vec)) begin
            code_d = kp_lowest(rel_vec);
        end
`endif
    end

`ifndef KEYPAD_RELEASE_EN
    logic unused_rel;
    assign unused_rel = ^{rel_vec, rel_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1_q <= '0;
            col_s2_q <= '0;
            div_q    <= '0;
            ridx_q   <= '0;
            row_q    <= KP_ROW_RST;
            raw_q    <= '0;
            frame_q  <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= '0;
            rel_q    <= 1'b0;
        end else begin
            col_s1_q <= col;
            col_s2_q <= col_s1_q;
            div_q    <= div_d;
            ridx_q   <= ridx_d;
            row_q    <= row_d;
            raw_q    <= raw_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            rel_q    <= rel_d;
        end
    end

    assign row       = row_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
`ifdef KEYPAD_RELEASE_EN
    assign key_release = rel_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner (SCAN_DIV=4, 3-frame debounce).
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int N  = 3;
    localparam int FR = 4 * SD;
`ifdef KEYPAD_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_release;
    logic [15:0] held = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its column to the active row.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) col = col & ~held[r*4 +: 4];
        end
    end

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .keys     (keys),
        .key_valid(key_valid),
        .key_code (key_code)
`ifdef KEYPAD_RELEASE_EN
        ,
        .key_release(key_release)
`endif
    );

`ifndef KEYPAD_RELEASE_EN
    assign key_release = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        bit          is_chk;
        bit          v;
        bit          r;
        logic [3:0]  code;
        logic [15:0] keys;
    } exp_t;

    exp_t sbq[$];

    logic [15:0] m_keys = '0;
    logic [3:0]  m_code = '0;
    logic [15:0] hist[$];
    int          fidx = 0;

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    // Reference: keys follow a frame once the last N frames since
    // reset are identical; new presses win the reported code.
    task automatic model_frame(input logic [15:0] h);
        bit stable;
        logic [15:0] np, rp;
        exp_t e;
        hist.push_back(h);
        if (hist.size() > N) void'(hist.pop_front());
        stable = (hist.size() == N);
        foreach (hist[i]) if (hist[i] != h) stable = 1'b0;
        if (stable && h != m_keys) begin
            np = h & ~m_keys;
            rp = m_keys & ~h;
            m_keys = h;
            e.v = |np;
            e.r = REL && (|rp);
            if (e.v) m_code = lowest(np);
            else if (e.r) m_code = lowest(rp);
            if (e.v || e.r) begin
                e.cyc = FR * fidx + FR + 1;
                e.is_chk = 1'b0;
                e.code = m_code;
                e.keys = m_keys;
                sbq.push_back(e);
            end
        end
        e.cyc = FR * fidx + FR + 2;
        e.is_chk = 1'b1;
        e.v = 1'b0;
        e.r = 1'b0;
        e.code = m_code;
        e.keys = m_keys;
        sbq.push_back(e);
        fidx++;
    endtask

    task automatic model_reset();
        hist.delete();
        m_keys = '0;
        m_code = '0;
        fidx = 0;
    endtask

    task automatic frame(input logic [15:0] h);
        held = h;
        repeat (FR) @(negedge clk);
        #1;
        model_frame(h);
    endtask

    task automatic frames(input logic [15:0] h, input int n);
        for (int i = 0; i < n; i++) frame(h);
    endtask

    // Monitor: scan order every cycle, events and key state as scheduled.
    always @(negedge clk) begin
        logic [3:0] er;
        logic pulse;
        exp_t e;
        if (!rst) begin
            er = ~(4'b0001 << ((cyc / SD) % 4));
            chk("row", row, er);
            pulse = key_valid | key_release;
            while (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("missed_entry_cyc", cyc, e.cyc);
            end
            if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                if (e.is_chk) begin
                    chk("keys", keys, e.keys);
                    chk("code_hold", key_code, e.code);
                    chk("idle_pulse", pulse, 1'b0);
                end else begin
                    chk("key_valid", key_valid, e.v);
                    chk("key_release", key_release, e.r);
                    chk("key_code", key_code, e.code);
                    chk("event_keys", keys, e.keys);
                end
            end else begin
                chk("spurious_pulse", pulse, 1'b0);
            end
        end
    end

    initial begin
        logic [31:0] rv;
        logic [15:0] h;
        int n;
        rst = 1'b1;
        held = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_row", row, 4'b1110);
            chk("rst_keys", keys, 16'h0);
            chk("rst_valid", key_valid, 1'b0);
            chk("rst_code", key_code, 4'h0);
            chk("rst_release", key_release, 1'b0);
        end
        #1 rst = 1'b0;

        frames(16'h0000, 2);
        // single press of key (2,1) = code 9, then its release
        frames(16'h0200, 6);
        frames(16'h0000, 4);
        // bounce on key 0, then steady hold
        for (int i = 0; i < 10; i++) frame((i % 2 == 0) ? 16'h0001 : 16'h0000);
        frames(16'h0001, 4);
        frames(16'h0000, 4);
        // simultaneous 5 and 14, release 5, re-press 5
        frames(16'h4020, 4);
        frames(16'h4000, 4);
        frames(16'h4020, 4);
        frames(16'h0000, 4);

        // reset during row 2 with key 15 held
        frame(16'h8000);
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_row", row, 4'b1110);
        chk("midrst_keys", keys, 16'h0);
        chk("midrst_valid", key_valid, 1'b0);
        #1 rst = 1'b0;
        model_reset();
        frames(16'h8000, 4);
        frames(16'h0000, 4);

        for (int s = 0; s < 40; s++) begin
            rv = $urandom();
            case ($urandom_range(0, 3))
                0: h = 16'h0000;
                1: h = 16'h0001 << $urandom_range(0, 15);
                2: h = (16'h0001 << $urandom_range(0, 15)) |
                       (16'h0001 << $urandom_range(0, 15));
                default: h = rv[15:0];
            endcase
            n = $urandom_range(1, 5);
            frames(h, n);
        end

        frames(16'h0000, 4);
        repeat (4) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
